// File: rtl/noc_seq_pkg.sv
// Router op encoding (matches the parameters.v defines) and the sequencer state type.
// NOC_SEQ_STEP_EN adds the PAUSE state used for single-stepping simulation cycles.
package noc_seq_pkg;

  localparam int OP_W = 3;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP          = 3'd0;
  localparam op_t OP_INIT         = 3'd1;
  localparam op_t OP_LOAD_RT      = 3'd2;
  localparam op_t OP_LOAD_STAGING = 3'd3;
  localparam op_t OP_PHASE0       = 3'd4;
  localparam op_t OP_PHASE1       = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT    = 4'd1,
    ST_LOAD_RT = 4'd2,
    ST_RT_LAST = 4'd3,
    ST_STAGE   = 4'd4,
    ST_PH0     = 4'd5,
    ST_PH1     = 4'd6,
    ST_DONE    = 4'd7
`ifdef NOC_SEQ_STEP_EN
    ,
    ST_PAUSE   = 4'd8
`endif
  } state_t;

  function automatic logic is_active(input state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/noc_op_fanout.sv
// Expands one op code into the flattened per-router op bus: broadcast to all routers,
// or only to the target index with NOP elsewhere (an out-of-range target gets no op).
module noc_op_fanout
  import noc_seq_pkg::*;
#(
  parameter int NUM_ROUTERS = 16,
  parameter int RIDX_W      = 4
) (
  input  logic [OP_W-1:0]             op_code,
  input  logic                        bcast,
  input  logic [RIDX_W-1:0]           target,
  output logic [OP_W*NUM_ROUTERS-1:0] op_bus
);

  always_comb begin
    op_bus = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      op_bus[OP_W*i +: OP_W] = (bcast || (target == RIDX_W'(i))) ? op_code : OP_NOP;
    end
  end

endmodule

// File: rtl/noc_sequencer.sv
// NoC sequencer: Init, host routing-table load, then LoadStaging/Phase0/Phase1 cycles
// until all routers are done or the cycle budget runs out. NOC_SEQ_STEP_EN adds a `step` gate.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no run yet; all NOP
// ST_INIT    | Init broadcast for INIT_CYCLES clocks
// ST_LOAD_RT | accepting routing entries; LoadRt to the addressed router
// ST_RT_LAST | LoadRt clock of the final entry, no further entries taken
// ST_STAGE   | LoadStaging broadcast
// ST_PH0     | Phase0 broadcast
// ST_PH1     | Phase1 broadcast; decides finish / timeout / next cycle
// ST_PAUSE   | (step build only) NOP until step
// ST_DONE    | run ended; finished/timeout held
module noc_sequencer
  import noc_seq_pkg::*;
#(
  parameter int NUM_ROUTERS = 16,
  parameter int RIDX_W      = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [15:0]                 max_cycles,
  input  logic                        rt_valid,
  output logic                        rt_ready,
  input  logic [RIDX_W-1:0]           rt_router,
  input  logic [31:0]                 rt_entry,
  input  logic                        rt_last,
`ifdef NOC_SEQ_STEP_EN
  input  logic                        step,
`endif
  input  logic [NUM_ROUTERS-1:0]      router_done,
  output logic [OP_W*NUM_ROUTERS-1:0] op,
  output logic [31:0]                 data,
  output logic [15:0]                 in_cycle,
  output logic                        busy,
  output logic                        finished,
  output logic                        timeout
);

  localparam int INIT_CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_CW-1:0] INIT_LOAD = INIT_CW'(INIT_CYCLES - 1);

  state_t                      state_q, state_d;
  logic [INIT_CW-1:0]          init_cnt_q, init_cnt_d;
  logic [15:0]                 budget_q, budget_d;
  logic [15:0]                 in_cycle_q, in_cycle_d;
  logic                        finished_q, finished_d;
  logic                        timeout_q, timeout_d;
  logic [OP_W*NUM_ROUTERS-1:0] op_q, op_d;
  logic [31:0]                 data_q, data_d;
  logic                        rt_ready_q, rt_ready_d;
  logic                        busy_q, busy_d;

  logic        rt_accept;
  logic [15:0] cycle_inc;
  op_t         fan_code;
  logic        fan_bcast;

  // rt_ready_q is high exactly while in LOAD_RT, so this is the host handshake.
  assign rt_accept = (state_q == ST_LOAD_RT) && rt_valid;
  assign cycle_inc = in_cycle_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      init_cnt_q <= '0;
      budget_q   <= '0;
      in_cycle_q <= '0;
      finished_q <= 1'b0;
      timeout_q  <= 1'b0;
      op_q       <= '0;
      data_q     <= '0;
      rt_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      budget_q   <= budget_d;
      in_cycle_q <= in_cycle_d;
      finished_q <= finished_d;
      timeout_q  <= timeout_d;
      op_q       <= op_d;
      data_q     <= data_d;
      rt_ready_q <= rt_ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    budget_d   = budget_q;
    in_cycle_d = in_cycle_q;
    finished_d = finished_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_INIT;
          init_cnt_d = INIT_LOAD;
          budget_d   = max_cycles;
          in_cycle_d = '0;
          finished_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_INIT: begin
        if (init_cnt_q == '0) begin
          state_d = ST_LOAD_RT;
        end else begin
          init_cnt_d = init_cnt_q - 1'b1;
        end
      end
      ST_LOAD_RT: begin
        if (rt_accept && rt_last) begin
          state_d = ST_RT_LAST;
        end
      end
      ST_RT_LAST: state_d = ST_STAGE;
      ST_STAGE:   state_d = ST_PH0;
      ST_PH0:     state_d = ST_PH1;
      ST_PH1: begin
        if (&router_done) begin
          state_d    = ST_DONE;
          finished_d = 1'b1;
        end else if ((budget_q != '0) && (cycle_inc == budget_q)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          in_cycle_d = cycle_inc;
`ifdef NOC_SEQ_STEP_EN
          state_d    = ST_PAUSE;
`else
          state_d    = ST_STAGE;
`endif
        end
      end
`ifdef NOC_SEQ_STEP_EN
      ST_PAUSE: begin
        if (step) begin
          state_d = ST_STAGE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each op lines up with its state.
  always_comb begin
    fan_code  = OP_NOP;
    fan_bcast = 1'b1;
    data_d    = data_q;
    case (state_d)
      ST_INIT:  fan_code = OP_INIT;
      ST_STAGE: fan_code = OP_LOAD_STAGING;
      ST_PH0:   fan_code = OP_PHASE0;
      ST_PH1:   fan_code = OP_PHASE1;
      default:  fan_code = OP_NOP;
    endcase
    if (rt_accept) begin
      fan_code  = OP_LOAD_RT;
      fan_bcast = 1'b0;
      data_d    = rt_entry;
    end
    rt_ready_d = (state_d == ST_LOAD_RT);
    busy_d     = is_active(state_d);
  end

  noc_op_fanout #(
    .NUM_ROUTERS(NUM_ROUTERS),
    .RIDX_W     (RIDX_W)
  ) u_fanout (
    .op_code(fan_code),
    .bcast  (fan_bcast),
    .target (rt_router),
    .op_bus (op_d)
  );

  assign op       = op_q;
  assign data     = data_q;
  assign in_cycle = in_cycle_q;
  assign rt_ready = rt_ready_q;
  assign busy     = busy_q;
  assign finished = finished_q;
  assign timeout  = timeout_q;

endmodule

// File: doc/noc_sequencer.md
# noc_sequencer

Top-level controller that drives the `op` command input of every router in the mesh. It runs `Init`, then streams routing-table entries from the host into individual routers with `LoadRt`. It then steps the network through repeated simulation cycles of `LoadStaging` → `Phase0` → `Phase1`, and stops when every router reports `done` or a cycle budget is exhausted. It owns the network's notion of time: the 16-bit `in_cycle` value shared by all routers.

## Interface
Parameters:
- `NUM_ROUTERS`, default 16: number of routers driven; flattened op bus width is 3*NUM_ROUTERS.
- `RIDX_W`, default 4: router index width, ≥ clog2(NUM_ROUTERS).
- `INIT_CYCLES`, default 2: clocks `Init` is held after start.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: pulse; begins a run from IDLE or DONE.
- `max_cycles`, in, 16: simulation-cycle budget; 0 = unlimited. Sampled on start.
- `rt_valid`, in, 1: host routing entry valid.
- `rt_ready`, out, 1: entry accepted this clock.
- `rt_router`, in, RIDX_W: target router of the entry.
- `rt_entry`, in, 32: entry payload (`[13:0]` dest, `[19:14]` out port).
- `rt_last`, in, 1: final routing entry.
- `router_done`, in, NUM_ROUTERS: `done` outputs of all routers.
- `op`, out, 3*NUM_ROUTERS: per-router op; router i uses bits `[3i+2:3i]`.
- `data`, out, 32: broadcast data bus to routers.
- `in_cycle`, out, 16: current simulation cycle, broadcast.
- `busy`, out, 1: not IDLE/DONE.
- `finished`, out, 1: run ended by all-done.
- `timeout`, out, 1: run ended by budget.

## Operation
- Op encodings are fixed: NOP=0, Init=1, LoadRt=2, LoadStaging=3, Phase0=4, Phase1=5; 6–7 are never driven.
- IDLE: all ops are NOP.
  - `start` → INIT. It clears `in_cycle`, `finished` and `timeout`, and latches `max_cycles`.
- INIT: all routers receive Init for INIT_CYCLES clocks → LOAD_RT.
- LOAD_RT: `rt_ready`=1.
  - On `rt_valid`, `data`←`rt_entry`; router `rt_router` gets LoadRt on the next clock and the others get NOP.
  - If `rt_router` ≥ NUM_ROUTERS, the entry is consumed and all routers get NOP.
  - An accepted entry with `rt_last` → STAGE after its LoadRt clock.
  - With no valid entry, all routers get NOP.
- STAGE → PH0 → PH1: each state lasts one clock and drives LoadStaging, Phase0 or Phase1 to all routers.
- PH1 samples `&router_done`. Routers register `done` on the Phase0 edge, so the value is valid here.
  - All done → DONE with `finished`=1.
  - Otherwise, if budget ≠ 0 and `in_cycle`+1 == budget → DONE with `timeout`=1.
  - Otherwise `in_cycle`←`in_cycle`+1 and → STAGE.
- DONE: all ops NOP; `finished` and `timeout` hold. `start` → INIT (new run).
- `start` outside IDLE/DONE is ignored.
- `in_cycle` is 16-bit and wraps 0xFFFF→0 with an unlimited budget.

## Timing
- All outputs are registered.
- Reset values: `op`=all NOP, `data`=0, `in_cycle`=0, `rt_ready`=0, `busy`=0, `finished`=0, `timeout`=0, state=IDLE.
- `start` at edge t: Init is visible from t+1 for INIT_CYCLES clocks.
- Steady state: 3 clocks per simulation cycle; `in_cycle` is stable across each STAGE/PH0/PH1 triple.
- `in_cycle` increments on the edge leaving PH1.
- Routing-table throughput: 1 entry per clock, with `data` and LoadRt presented together.
- Reset mid-run is asynchronous: ops go to NOP at once, and any partially loaded table is abandoned.

## Configuration
- `NOC_SEQ_STEP_EN`, when defined:
  - Adds an input `step` (1 bit) and a state PAUSE entered after every PH1 that does not terminate.
  - PAUSE drives NOP and waits for `step`; `step` advances to STAGE with the incremented cycle.
- When undefined: no `step` port and no PAUSE state; PH1 goes directly to STAGE.

## Structure
- Package `noc_seq_pkg`: the op encoding constants (which match the `parameters.v` defines) and the state enum.
- Sub-module `noc_op_fanout`: takes the op code, a broadcast flag and a target index, and produces the flattened per-router op bus with NOP on non-targets.

## Test plan
- Reset then start, INIT_CYCLES=2, three entries to routers 0, 5, 15 (last on the third) → Init×2, then LoadRt only on router 0/5/15 in successive clocks with matching `data`, then LoadStaging on all.
- `router_done` forced to all-1 from cycle 4 → PH1 of `in_cycle`=4 gives `finished`=1 and `in_cycle`=4; all ops NOP thereafter.
- `max_cycles`=10, `router_done`=0 → `timeout`=1 after PH1 with `in_cycle`=9; `finished`=0.
- `rt_router`=20 with NUM_ROUTERS=16 → entry accepted, all ops NOP that clock.
- Assert `rst_n` low during PH0 → ops go to NOP immediately (asynchronously); after release, state is IDLE and `busy`=0.
- With `NOC_SEQ_STEP_EN`: after the first PH1, ops are NOP until `step`; `step` yields LoadStaging with `in_cycle`=1.
